fp_cmp_prep: RTL and testbench
==============================

FP_CMP_PREP -- requirements
Module: fp_cmp_prep

Interface
REQ-001 clock  in  1  rising-edge clock for all state.
REQ-002 reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-003 in_valid  in  1  operand pair presented.
REQ-004 in_ready  out  1  stage 1 can accept a pair this cycle.
REQ-005 data1, data2  in  64 each  raw operands; single precision NaN-boxed in [31:0].
REQ-006 fmt  in  2  0 = single, 1 = double; 2 and 3 are treated as double.
REQ-007 rm  in  3  min/max select, passed through unchanged (0 = min, 1 = max).
REQ-008 flush  in  1  synchronous kill of all in-flight pairs.
REQ-009 out_valid  out  1  out holds a valid fp_max_in_type.
REQ-010 out_ready  in  1  downstream min/max stage consumes out this cycle.
REQ-011 out  out  fp_max_in_type  data1, data2, ext1, ext2, fmt, rm, class1, class2 for the min/max stage.

Function
REQ-012 Two-stage pipeline. S1 registers the inputs and the per-operand classification plus the leading-zero count. S2 registers the normalised ext values and the final bundle.
REQ-013 Latency: with out_ready held at 1, out_valid rises 2 cycles after the in_valid&&in_ready edge; throughput is 1 pair per cycle.
REQ-014 in_ready = !s1_valid || s1_advance, where s1_advance = !s2_valid || out_ready.
REQ-015 out and out_valid hold stable while out_valid && !out_ready; no pair is dropped or duplicated.
REQ-016 NaN-box check: if fmt==0 and data[63:32] != 32'hFFFFFFFF, the operand is treated as canonical qNaN 32'h7FC00000 for ext and class. out.dataN carries that canonical value zero-extended.
REQ-017 class is a 10-bit one-hot vector:
  - bits 0..7: -inf, -normal, -subnormal, -zero, +zero, +subnormal, +normal, +inf
  - bit 8: sNaN (quiet bit 0, mantissa != 0)
  - bit 9: qNaN
REQ-018 ext[64] = sign and ext[63] = 0 for both formats.
REQ-019 Double: ext[62:0] = data[62:0].
REQ-020 Single normal: ext[62:52] = exp8 + 896 and ext[51:0] = {m23, 29'b0}.
REQ-021 Single zero: ext[62:0] = 0.
REQ-022 Single inf/NaN: ext[62:52] = 2047 and ext[51:0] = {m23, 29'b0}.
REQ-023 Single subnormal: lz = leading zeros of m23 (0..22); ext[62:52] = 896 - lz; ext[51:0] = {(m23 << (lz+1))[22:0], 29'b0}.
REQ-024 ext[63:0] is magnitude-monotonic for all non-NaN inputs of one fmt, so an unsigned compare orders magnitudes.
REQ-025 out.fmt and out.rm equal the values captured with the pair.
REQ-026 flush=1 clears s1_valid and s2_valid at the next edge, overriding capture. If flush and in_valid are both 1, in_ready may be 1, but the pair is discarded.

Reset
REQ-027 On reset=0: s1_valid=0, s2_valid=0, out_valid=0, and all out fields are 0. in_ready=1 once reset=1.
REQ-028 Reset asserted mid-transfer discards all in-flight pairs. No out_valid appears for them after release.

Structure
REQ-029 The fp_cmp_prep_reg_type (S1/S2 records) and the constants CANON_NAN32 = 32'h7FC00000 and SP2DP_BIAS = 896 live in package fp_wire, next to fp_max_in_type.
REQ-030 A combinational sub-module fp_ext (operand in: data, fmt; out: ext, class, lz) is instantiated twice, once per operand. fp_cmp_prep owns only pipeline registers and the handshake.

Verification
REQ-031 fmt=1, data1=0x3FF0000000000000, data2=0xBFF0000000000000, out_ready=1 -> 2 cycles later:
  - ext1 = 0x0_3FF0000000000000, class1 = 0x040
  - ext2[64] = 1, class2 = 0x002
REQ-032 fmt=0, data1=0xFFFFFFFF00000001 -> ext1 = 0x0_36A0000000000000, class1 = 0x020. fmt=0, data1=0x000000003F800000 -> class1 = 0x200, out.data1 = 0x7FC00000.
REQ-033 fmt=0, data1=0xFFFFFFFF7F800001 -> class1 = 0x100; 0xFFFFFFFF80000000 -> class1 = 0x008, ext1 = 0x1_0000000000000000.
REQ-034 Stream 6 pairs with out_ready toggling 1,0,0,1,... -> all 6 pairs emerge in order. out is stable during stall cycles. in_ready=0 only when both stages are full and stalled.
REQ-035 Assert flush with 2 pairs in flight -> no out_valid follows. The next pair after flush appears after 2 cycles.
REQ-036 Pull reset low while out_valid=1 -> out_valid=0 within the same cycle (asynchronous); after release, in_ready=1 and out_valid=0.

Source files
------------

// File: rtl/fp_wire.sv
// Shared types and constants for the FP compare/min-max front end.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: fp_max_in_type (min/max stage input bundle), fp_cmp_prep S1/S2
// register records, single-to-double constants and NaN-box helpers.
package fp_wire;

  localparam logic [31:0] CANON_NAN32 = 32'h7FC00000;
  localparam logic [10:0] SP2DP_BIAS  = 11'd896;  // 1023 - 127

  typedef struct packed {
    logic [63:0] data1;
    logic [63:0] data2;
    logic [64:0] ext1;
    logic [64:0] ext2;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [9:0]  class1;
    logic [9:0]  class2;
  } fp_max_in_type;

  typedef struct packed {
    logic        vld;
    logic [63:0] data1;
    logic [63:0] data2;
    logic [64:0] ext1;
    logic [64:0] ext2;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [9:0]  class1;
    logic [9:0]  class2;
    logic [4:0]  lz1;
    logic [4:0]  lz2;
  } fp_cmp_prep_s1_type;

  typedef struct packed {
    fp_cmp_prep_s1_type s1;
    logic               s2_vld;
    fp_max_in_type      s2;
  } fp_cmp_prep_reg_type;

  // Upper half all ones means a properly NaN-boxed single.
  function automatic logic nanbox_ok(input logic [63:0] d);
    return d[63:32] == 32'hFFFFFFFF;
  endfunction

  // Leading zeros of a 23-bit mantissa; 23 when the mantissa is zero.
  function automatic logic [4:0] lzc23(input logic [22:0] m);
    logic [4:0] n;
    n = 5'd23;
    for (int i = 0; i < 23; i++) begin
      if (m[i]) n = 5'(22 - i);  // highest set bit wins (loop runs upward)
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_ext.sv
// Per-operand classifier: builds the 65-bit magnitude-ordered ext value,
// the 10-bit one-hot class and the single-precision mantissa lz count.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: data/fmt in; ext, cls, lz out.
module fp_ext
  import fp_wire::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  fmt,
  output logic [64:0] ext,
  output logic [9:0]  cls,
  output logic [4:0]  lz
);

  logic        sp;
  logic [31:0] s32;
  logic [22:0] m23;
  logic [22:0] sh23;
  logic        sign;
  logic        e_zero;
  logic        e_max;
  logic        m_zero;
  logic        quiet;

  always_comb begin
    sp   = (fmt == 2'd0);
    // An unboxed single behaves exactly like the canonical quiet NaN.
    s32  = nanbox_ok(data) ? data[31:0] : CANON_NAN32;
    m23  = s32[22:0];
    lz   = lzc23(m23);
    // Shift out the leading one so the subnormal becomes an implicit-1 value.
    sh23 = m23 << (lz + 5'd1);

    if (sp) begin
      sign   = s32[31];
      e_zero = (s32[30:23] == 8'h00);
      e_max  = (s32[30:23] == 8'hFF);
      m_zero = (m23 == 23'd0);
      quiet  = m23[22];
    end else begin
      sign   = data[63];
      e_zero = (data[62:52] == 11'h000);
      e_max  = (data[62:52] == 11'h7FF);
      m_zero = (data[51:0] == 52'd0);
      quiet  = data[51];
    end

    ext     = '0;
    ext[64] = sign;
    if (!sp) begin
      ext[62:0] = data[62:0];
    end else if (e_max) begin
      ext[62:52] = 11'h7FF;
      ext[51:29] = m23;
    end else if (e_zero) begin
      if (!m_zero) begin
        ext[62:52] = SP2DP_BIAS - {6'd0, lz};
        ext[51:29] = sh23;
      end
    end else begin
      ext[62:52] = SP2DP_BIAS + {3'd0, s32[30:23]};
      ext[51:29] = m23;
    end

    cls = '0;
    if (e_max && !m_zero) begin
      if (quiet) cls[9] = 1'b1;
      else       cls[8] = 1'b1;
    end else if (e_max) begin
      if (sign) cls[0] = 1'b1; else cls[7] = 1'b1;
    end else if (e_zero && m_zero) begin
      if (sign) cls[3] = 1'b1; else cls[4] = 1'b1;
    end else if (e_zero) begin
      if (sign) cls[2] = 1'b1; else cls[5] = 1'b1;
    end else begin
      if (sign) cls[1] = 1'b1; else cls[6] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_cmp_prep.sv
// Two-stage operand prep for the FP min/max unit: S1 holds inputs, class, lz, S2 the final bundle.
// Latency: 2 cycles from accept to out_valid; 1 pair/cycle throughput.
// Backpressure: out_ready low holds S2; in_ready drops only when S1 and S2 are both full and stalled.
// Ports: clock/reset, in_valid/in_ready + data1/data2/fmt/rm, flush, out_valid/out_ready + out.
module fp_cmp_prep
  import fp_wire::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   data1,
  input  logic [63:0]   data2,
  input  logic [1:0]    fmt,
  input  logic [2:0]    rm,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output fp_max_in_type out
);

  fp_cmp_prep_reg_type r_q, r_d;

  logic [64:0] ext1, ext2;
  logic [9:0]  cls1, cls2;
  logic [4:0]  lz1, lz2;
  logic        s1_advance;

  fp_ext u_ext1 (.data(data1), .fmt(fmt), .ext(ext1), .cls(cls1), .lz(lz1));
  fp_ext u_ext2 (.data(data2), .fmt(fmt), .ext(ext2), .cls(cls2), .lz(lz2));

  assign s1_advance = !r_q.s2_vld || out_ready;
  assign in_ready   = !r_q.s1.vld || s1_advance;
  assign out_valid  = r_q.s2_vld;
  assign out        = r_q.s2;

  // lz is held in S1 for the normalisation path; nothing downstream consumes it.
  logic [9:0] unused_lz;
  assign unused_lz = {r_q.s1.lz1, r_q.s1.lz2};

  always_comb begin
    r_d = r_q;

    if (s1_advance) begin
      r_d.s2_vld = r_q.s1.vld;
      if (r_q.s1.vld) begin
        r_d.s2.data1  = r_q.s1.data1;
        r_d.s2.data2  = r_q.s1.data2;
        r_d.s2.ext1   = r_q.s1.ext1;
        r_d.s2.ext2   = r_q.s1.ext2;
        r_d.s2.fmt    = r_q.s1.fmt;
        r_d.s2.rm     = r_q.s1.rm;
        r_d.s2.class1 = r_q.s1.class1;
        r_d.s2.class2 = r_q.s1.class2;
      end
    end

    if (in_ready) begin
      r_d.s1.vld = in_valid;
      if (in_valid) begin
        // Unboxed singles are forwarded as the canonical NaN they are treated as.
        r_d.s1.data1  = (fmt == 2'd0 && !nanbox_ok(data1)) ? {32'd0, CANON_NAN32} : data1;
        r_d.s1.data2  = (fmt == 2'd0 && !nanbox_ok(data2)) ? {32'd0, CANON_NAN32} : data2;
        r_d.s1.ext1   = ext1;
        r_d.s1.ext2   = ext2;
        r_d.s1.fmt    = fmt;
        r_d.s1.rm     = rm;
        r_d.s1.class1 = cls1;
        r_d.s1.class2 = cls2;
        r_d.s1.lz1    = lz1;
        r_d.s1.lz2    = lz2;
      end
    end

    // Flush wins over any capture in the same cycle.
    if (flush) begin
      r_d.s1.vld = 1'b0;
      r_d.s2_vld = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_q <= '0;
    else        r_q <= r_d;
  end

endmodule

// File: tb/tb_fp_cmp_prep.sv
// Directed bench for fp_cmp_prep: classification vectors, streaming with stalls, flush, async reset.
// Latency: checks 2-cycle accept-to-output timing.
// Backpressure: exercises out_ready toggling and in_ready stall behaviour.
module tb_fp_cmp_prep;
  import fp_wire::*;

  logic          clock = 1'b0;
  logic          reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [63:0]   data1, data2;
  logic [1:0]    fmt;
  logic [2:0]    rm;
  fp_max_in_type out_s;
  fp_max_in_type held;
  int            n_vec = 0;
  int            n_bad = 0;
  int            tx, rx, cyc;
  logic          acc, cons, stalled;

  always #5 clock = ~clock;

  fp_cmp_prep dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data1(data1), .data2(data2), .fmt(fmt), .rm(rm), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_s)
  );

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one pair, then confirm it is invisible after one edge and valid after two.
  task automatic send_pair(input logic [63:0] d1, input logic [63:0] d2,
                           input logic [1:0] f, input logic [2:0] r);
    @(posedge clock); #1;
    in_valid = 1'b1; data1 = d1; data2 = d2; fmt = f; rm = r; out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    check("lat1_vld", 65'(out_valid), 65'd0);
    @(posedge clock);
    @(negedge clock);
    check("lat2_vld", 65'(out_valid), 65'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    data1 = '0; data2 = '0; fmt = '0; rm = '0;
    #2;
    check("rst_vld", 65'(out_valid), 65'd0);
    check("rst_out_zero", 65'(out_s == '0), 65'd1);
    @(negedge clock); reset = 1'b1; #1;
    check("rst_in_rdy", 65'(in_ready), 65'd1);

    // Double +1.0 / -1.0
    send_pair(64'h3FF0000000000000, 64'hBFF0000000000000, 2'd1, 3'd1);
    check("dp_ext1", out_s.ext1, 65'h0_3FF0000000000000);
    check("dp_cls1", 65'(out_s.class1), 65'h040);
    check("dp_ext2_sign", 65'(out_s.ext2[64]), 65'd1);
    check("dp_cls2", 65'(out_s.class2), 65'h002);
    check("dp_rm", 65'(out_s.rm), 65'd1);
    check("dp_fmt", 65'(out_s.fmt), 65'd1);

    // Single min subnormal / single 1.0
    send_pair(64'hFFFFFFFF00000001, 64'hFFFFFFFF3F800000, 2'd0, 3'd0);
    check("sp_sub_ext", out_s.ext1, 65'h0_36A0000000000000);
    check("sp_sub_cls", 65'(out_s.class1), 65'h020);
    check("sp_one_ext", out_s.ext2, 65'h0_3FF0000000000000);
    check("sp_one_cls", 65'(out_s.class2), 65'h040);

    // Unboxed single -> canonical qNaN; boxed sNaN
    send_pair(64'h000000003F800000, 64'hFFFFFFFF7F800001, 2'd0, 3'd0);
    check("unbox_cls", 65'(out_s.class1), 65'h200);
    check("unbox_dat", 65'(out_s.data1), 65'h7FC00000);
    check("unbox_ext", out_s.ext1, 65'h0_7FF8000000000000);
    check("snan_cls", 65'(out_s.class2), 65'h100);
    check("snan_ext", out_s.ext2, 65'h0_7FF0000020000000);
    check("snan_dat", 65'(out_s.data2), 65'hFFFFFFFF7F800001);

    // Single -0 / -inf
    send_pair(64'hFFFFFFFF80000000, 64'hFFFFFFFFFF800000, 2'd0, 3'd0);
    check("nzero_cls", 65'(out_s.class1), 65'h008);
    check("nzero_ext", out_s.ext1, 65'h1_0000000000000000);
    check("ninf_cls", 65'(out_s.class2), 65'h001);
    check("ninf_ext", out_s.ext2, 65'h1_7FF0000000000000);

    // Largest single subnormal vs smallest single normal: ordering across the boundary
    send_pair(64'hFFFFFFFF007FFFFF, 64'hFFFFFFFF00800000, 2'd0, 3'd0);
    check("maxsub_ext", out_s.ext1, 65'h0_380FFFFFC0000000);
    check("minnorm_ext", out_s.ext2, 65'h0_3810000000000000);
    check("sub_lt_norm", 65'(out_s.ext1 < out_s.ext2), 65'd1);

    // fmt=2 treated as double: no NaN-box check, double subnormal and -0
    send_pair(64'h0000000000000001, 64'h8000000000000000, 2'd2, 3'd0);
    check("f2_sub_cls", 65'(out_s.class1), 65'h020);
    check("f2_sub_ext", out_s.ext1, 65'h0_0000000000000001);
    check("f2_nz_cls", 65'(out_s.class2), 65'h008);
    check("f2_fmt", 65'(out_s.fmt), 65'd2);

    // Double +inf / qNaN
    send_pair(64'h7FF0000000000000, 64'h7FF8000000000000, 2'd1, 3'd0);
    check("dinf_cls", 65'(out_s.class1), 65'h080);
    check("dqnan_cls", 65'(out_s.class2), 65'h200);

    // Streaming 6 pairs with out_ready 1,0,0,1,0,0,...
    @(posedge clock); #1;
    tx = 0; rx = 0; cyc = 0; stalled = 1'b0; held = '0;
    in_valid = 1'b1; data1 = 64'h3FF0000000000000; data2 = 64'd0; fmt = 2'd1; rm = 3'd0;
    out_ready = 1'b1;
    while (rx < 6 && cyc < 60) begin
      @(negedge clock);
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      check("strm_rdy", 65'(in_ready), 65'(!((tx - rx) == 2 && !out_ready)));
      if (stalled) begin
        check("strm_hold_vld", 65'(out_valid), 65'd1);
        check("strm_hold_dat", 65'(out_s === held), 65'd1);
      end
      if (cons) begin
        check("strm_d1", 65'(out_s.data1), 65'(64'h3FF0000000000000 + 64'(rx)));
        check("strm_ext2", out_s.ext2, 65'(rx));
      end
      stalled = out_valid && !out_ready;
      held    = out_s;
      @(posedge clock);
      if (acc)  tx++;
      if (cons) rx++;
      #1;
      cyc++;
      in_valid  = (tx < 6);
      data1     = 64'h3FF0000000000000 + 64'(tx);
      data2     = 64'(tx);
      out_ready = (cyc % 3 == 0);
    end
    check("strm_count", 65'(rx), 65'd6);
    in_valid = 1'b0;
    @(negedge clock);
    check("strm_drain", 65'(out_valid), 65'd0);

    // Flush with two pairs in flight
    @(posedge clock); #1;
    in_valid = 1'b1; data1 = 64'hAAAA; data2 = 64'd0; fmt = 2'd1; out_ready = 1'b0;
    @(posedge clock); #1;
    data1 = 64'hBBBB;
    @(posedge clock); #1;
    data1 = 64'hCCCC; flush = 1'b1;
    @(negedge clock);
    check("fl_pre_vld", 65'(out_valid), 65'd1);
    check("fl_full_rdy", 65'(in_ready), 65'd0);
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("fl_quiet", 65'(out_valid), 65'd0);
    end
    send_pair(64'h4000000000000000, 64'hC000000000000000, 2'd1, 3'd1);
    check("fl_next_d1", 65'(out_s.data1), 65'h4000000000000000);
    check("fl_next_cls2", 65'(out_s.class2), 65'h002);

    // Async reset with out_valid high and a second pair in S1
    @(posedge clock); #1;
    in_valid = 1'b1; data1 = 64'h1111; out_ready = 1'b0;
    @(posedge clock); #1;
    data1 = 64'h2222;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    check("ar_pre_vld", 65'(out_valid), 65'd1);
    reset = 1'b0;
    #1;
    check("ar_async_vld", 65'(out_valid), 65'd0);
    check("ar_out_zero", 65'(out_s == '0), 65'd1);
    @(negedge clock);
    reset = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("ar_post_vld", 65'(out_valid), 65'd0);
    end
    check("ar_post_rdy", 65'(in_ready), 65'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
